// File: rtl/commit_trace_buffer.sv
// commit_trace_buffer: multi-lane commit-stage trace collector.
// Normalises retired instructions, tags them with sequence numbers, queues
// them in a FIFO and drains one entry per cycle over a valid/ready port.
// Keeps retire/drop counters, a sticky overflow flag and a hang watchdog.
// Optional build macro TRACE_DISPLAY_EN prints each pop and each dropped group.
module commit_trace_buffer #(
  parameter int unsigned NRET         = 2,
  parameter int unsigned XLEN         = 64,
  parameter int unsigned DEPTH        = 16,
  parameter int unsigned SEQW         = 32,
  parameter int unsigned HANG_TIMEOUT = 1024
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NRET-1:0]      ret_valid_i,
  input  logic [NRET*64-1:0]   ret_pc_i,
  input  logic [NRET*32-1:0]   ret_inst_i,
  input  logic [NRET-1:0]      ret_wb_valid_i,
  input  logic [NRET*5-1:0]    ret_rd_i,
  input  logic [NRET*XLEN-1:0] ret_data_i,
  output logic                 trace_valid_o,
  input  logic                 trace_ready_i,
  output logic [63:0]          trace_pc_o,
  output logic [31:0]          trace_inst_o,
  output logic [4:0]           trace_rd_o,
  output logic [XLEN-1:0]      trace_data_o,
  output logic [SEQW-1:0]      trace_seq_o,
  output logic [SEQW-1:0]      retire_cnt_o,
  output logic [SEQW-1:0]      drop_cnt_o,
  output logic                 overflow_o,
  output logic                 hang_o
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = AW + 1;
  localparam int unsigned KW = $clog2(NRET + 1);
  localparam int unsigned IW = (HANG_TIMEOUT > 0) ? $clog2(HANG_TIMEOUT + 1) : 1;

  // FIFO storage (payload only; occupancy lives in the pointer/count registers)
  logic [63:0]      r_pc_mem   [DEPTH];
  logic [31:0]      r_inst_mem [DEPTH];
  logic [4:0]       r_rd_mem   [DEPTH];
  logic [XLEN-1:0]  r_data_mem [DEPTH];
  logic [SEQW-1:0]  r_seq_mem  [DEPTH];

  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic [SEQW-1:0]  r_retire_cnt;
  logic [SEQW-1:0]  r_drop_cnt;
  logic             r_overflow;
  logic             r_hang;

  logic [KW-1:0]    w_k;
  logic [KW-1:0]    w_off  [NRET];
  logic [4:0]       w_rd   [NRET];
  logic [XLEN-1:0]  w_data [NRET];
  logic [CW-1:0]    w_free;
  logic             w_accept;
  logic             w_drop;
  logic             w_pop;

  // Lane popcount, per-lane slot offset among valid lanes, rd/data normalisation
  always_comb begin
    w_k = '0;
    for (int n = 0; n < NRET; n++) begin
      w_off[n]  = w_k;
      w_k       = w_k + KW'(ret_valid_i[n]);
      w_rd[n]   = ret_wb_valid_i[n] ? ret_rd_i[5*n +: 5] : 5'd0;
      w_data[n] = (ret_wb_valid_i[n] && (ret_rd_i[5*n +: 5] != 5'd0))
                  ? ret_data_i[XLEN*n +: XLEN] : '0;
    end
  end

  // All-or-nothing admission against free space at cycle start (no pop credit)
  always_comb begin
    w_free   = CW'(DEPTH) - r_count;
    w_accept = (w_k != '0) && (CW'(w_k) <= w_free);
    w_drop   = (w_k != '0) && !w_accept;
    w_pop    = trace_valid_o && trace_ready_i;
  end

  // Payload write: each valid lane lands at wr_ptr + its offset, in lane order
  always_ff @(posedge clk) begin
    if (w_accept) begin
      for (int n = 0; n < NRET; n++) begin
        if (ret_valid_i[n]) begin
          r_pc_mem  [r_wr_ptr + AW'(w_off[n])] <= ret_pc_i[64*n +: 64];
          r_inst_mem[r_wr_ptr + AW'(w_off[n])] <= ret_inst_i[32*n +: 32];
          r_rd_mem  [r_wr_ptr + AW'(w_off[n])] <= w_rd[n];
          r_data_mem[r_wr_ptr + AW'(w_off[n])] <= w_data[n];
          r_seq_mem [r_wr_ptr + AW'(w_off[n])] <= r_retire_cnt + SEQW'(w_off[n]);
        end
      end
    end
  end

  // Pointers, occupancy, retire/drop counters and sticky overflow
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_count      <= '0;
      r_retire_cnt <= '0;
      r_drop_cnt   <= '0;
      r_overflow   <= 1'b0;
    end else begin
      if (w_accept) r_wr_ptr <= r_wr_ptr + AW'(w_k);
      if (w_pop)    r_rd_ptr <= r_rd_ptr + AW'(1);
      r_count      <= r_count + (w_accept ? CW'(w_k) : CW'(0)) - CW'(w_pop);
      r_retire_cnt <= r_retire_cnt + SEQW'(w_k);
      if (w_drop) begin
        r_drop_cnt <= r_drop_cnt + SEQW'(w_k);
        r_overflow <= 1'b1;
      end
    end
  end

  generate
    if (HANG_TIMEOUT == 0) begin : g_no_wd
      assign r_hang = 1'b0;
    end else begin : g_wd
      logic [IW-1:0] r_idle;
      // Idle-cycle counter (saturating) and hang flag, both cleared by any retire
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_idle <= '0;
          r_hang <= 1'b0;
        end else if (w_k != '0) begin
          r_idle <= '0;
          r_hang <= 1'b0;
        end else begin
          if (r_idle != IW'(HANG_TIMEOUT)) r_idle <= r_idle + IW'(1);
          if (r_idle == IW'(HANG_TIMEOUT - 1)) r_hang <= 1'b1;
        end
      end
    end
  endgenerate

  // Head is shown ahead; payload is forced to zero while the FIFO is empty
  assign trace_valid_o = (r_count != '0);
  assign trace_pc_o    = trace_valid_o ? r_pc_mem[r_rd_ptr]   : '0;
  assign trace_inst_o  = trace_valid_o ? r_inst_mem[r_rd_ptr] : '0;
  assign trace_rd_o    = trace_valid_o ? r_rd_mem[r_rd_ptr]   : '0;
  assign trace_data_o  = trace_valid_o ? r_data_mem[r_rd_ptr] : '0;
  assign trace_seq_o   = trace_valid_o ? r_seq_mem[r_rd_ptr]  : '0;
  assign retire_cnt_o  = r_retire_cnt;
  assign drop_cnt_o    = r_drop_cnt;
  assign overflow_o    = r_overflow;
  assign hang_o        = r_hang;

`ifdef TRACE_DISPLAY_EN
  // Simulation trace log of pops and dropped groups
  always @(posedge clk) begin
    if (!rst && w_pop)
      $display("[%t][WB] seq: %0d, pc: %08h, inst: %08h, rd: %02d, rd_data: %016h",
               $time, trace_seq_o, trace_pc_o, trace_inst_o, trace_rd_o, trace_data_o);
    if (!rst && w_drop)
      $display("[%t][WB] DROP n=%0d", $time, w_k);
  end
`else
  // Trace printing is not compiled in this build.
`endif

endmodule

// File: tb/tb_commit_trace_buffer.sv
// Self-checking bench for commit_trace_buffer: directed tables and sequences
// plus randomized traffic compared against a queue-based reference model.
module tb_commit_trace_buffer;

  localparam int unsigned NRET  = 2;
  localparam int unsigned XLEN  = 64;
  localparam int unsigned DEPTH = 16;
  localparam int unsigned SEQW  = 32;
  localparam int unsigned HT    = 8;

  logic                 clk;
  logic                 rst;
  logic [NRET-1:0]      ret_valid_i;
  logic [NRET*64-1:0]   ret_pc_i;
  logic [NRET*32-1:0]   ret_inst_i;
  logic [NRET-1:0]      ret_wb_valid_i;
  logic [NRET*5-1:0]    ret_rd_i;
  logic [NRET*XLEN-1:0] ret_data_i;
  logic                 trace_valid_o;
  logic                 trace_ready_i;
  logic [63:0]          trace_pc_o;
  logic [31:0]          trace_inst_o;
  logic [4:0]           trace_rd_o;
  logic [XLEN-1:0]      trace_data_o;
  logic [SEQW-1:0]      trace_seq_o;
  logic [SEQW-1:0]      retire_cnt_o;
  logic [SEQW-1:0]      drop_cnt_o;
  logic                 overflow_o;
  logic                 hang_o;

  commit_trace_buffer #(
    .NRET(NRET), .XLEN(XLEN), .DEPTH(DEPTH), .SEQW(SEQW), .HANG_TIMEOUT(HT)
  ) dut (
    .clk(clk), .rst(rst),
    .ret_valid_i(ret_valid_i), .ret_pc_i(ret_pc_i), .ret_inst_i(ret_inst_i),
    .ret_wb_valid_i(ret_wb_valid_i), .ret_rd_i(ret_rd_i), .ret_data_i(ret_data_i),
    .trace_valid_o(trace_valid_o), .trace_ready_i(trace_ready_i),
    .trace_pc_o(trace_pc_o), .trace_inst_o(trace_inst_o), .trace_rd_o(trace_rd_o),
    .trace_data_o(trace_data_o), .trace_seq_o(trace_seq_o),
    .retire_cnt_o(retire_cnt_o), .drop_cnt_o(drop_cnt_o),
    .overflow_o(overflow_o), .hang_o(hang_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  // Reference model: a queue of trace records plus plain counters
  typedef struct {
    logic [63:0] pc;
    logic [31:0] inst;
    logic [4:0]  rd;
    logic [63:0] data;
    logic [31:0] seq;
  } ent_t;

  ent_t        mq[$];
  logic [31:0] m_retire;
  logic [31:0] m_drop;
  logic        m_ovf;
  int          m_idle;
  logic        m_hang;

  typedef struct {
    logic        wb;
    logic [4:0]  rd;
    logic [63:0] data;
    logic [4:0]  e_rd;
    logic [63:0] e_data;
  } vec_t;

  vec_t tbl[6];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_retire = '0;
    m_drop   = '0;
    m_ovf    = 1'b0;
    m_idle   = 0;
    m_hang   = 1'b0;
  endtask

  // One clock of the specification's rules applied to the current inputs
  task automatic model_step();
    int   k;
    int   idx;
    bit   acc;
    ent_t e;
    k = 0;
    for (int n = 0; n < NRET; n++) if (ret_valid_i[n]) k++;
    acc = (k > 0) && (k <= (DEPTH - mq.size()));
    if (mq.size() != 0 && trace_ready_i) mq.delete(0);
    idx = 0;
    for (int n = 0; n < NRET; n++) begin
      if (ret_valid_i[n]) begin
        if (acc) begin
          e.pc   = ret_pc_i[64*n +: 64];
          e.inst = ret_inst_i[32*n +: 32];
          e.rd   = ret_wb_valid_i[n] ? ret_rd_i[5*n +: 5] : 5'd0;
          e.data = (ret_wb_valid_i[n] && ret_rd_i[5*n +: 5] != 5'd0) ? ret_data_i[64*n +: 64] : 64'd0;
          e.seq  = m_retire + 32'(idx);
          mq.push_back(e);
        end
        idx++;
      end
    end
    m_retire = m_retire + 32'(k);
    if (k > 0 && !acc) begin
      m_drop = m_drop + 32'(k);
      m_ovf  = 1'b1;
    end
    if (k > 0) begin
      m_idle = 0;
      m_hang = 1'b0;
    end else begin
      m_idle++;
      if (m_idle >= HT) m_hang = 1'b1;
    end
  endtask

  task automatic check_model();
    chk("trace_valid", 64'(trace_valid_o), 64'(mq.size() != 0));
    if (mq.size() != 0) begin
      chk("head_pc",   trace_pc_o,          mq[0].pc);
      chk("head_inst", 64'(trace_inst_o),   64'(mq[0].inst));
      chk("head_rd",   64'(trace_rd_o),     64'(mq[0].rd));
      chk("head_data", trace_data_o,        mq[0].data);
      chk("head_seq",  64'(trace_seq_o),    64'(mq[0].seq));
    end
    chk("retire_cnt", 64'(retire_cnt_o), 64'(m_retire));
    chk("drop_cnt",   64'(drop_cnt_o),   64'(m_drop));
    chk("overflow",   64'(overflow_o),   64'(m_ovf));
    chk("hang",       64'(hang_o),       64'(m_hang));
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    check_model();
  endtask

  task automatic clear_inputs();
    ret_valid_i    = '0;
    ret_pc_i       = '0;
    ret_inst_i     = '0;
    ret_wb_valid_i = '0;
    ret_rd_i       = '0;
    ret_data_i     = '0;
  endtask

  task automatic set_lane(input int n, input logic v, input logic wb, input logic [4:0] rd,
                          input logic [63:0] pc, input logic [31:0] inst, input logic [63:0] data);
    ret_valid_i[n]        = v;
    ret_wb_valid_i[n]     = wb;
    ret_rd_i[5*n +: 5]    = rd;
    ret_pc_i[64*n +: 64]  = pc;
    ret_inst_i[32*n +: 32] = inst;
    ret_data_i[64*n +: 64] = data;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear_inputs();
    trace_ready_i = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic fill_groups(input int ngroups);
    for (int g = 0; g < ngroups; g++) begin
      set_lane(0, 1'b1, 1'b1, 5'(g + 1), 64'h2000 + 64'(8*g), 32'h13, 64'(g));
      set_lane(1, 1'b1, 1'b1, 5'(g + 2), 64'h2004 + 64'(8*g), 32'h93, 64'(g + 100));
      cycle();
    end
  endtask

  initial begin
    tbl[0] = '{wb: 1'b1, rd: 5'd0,  data: 64'hFF,                  e_rd: 5'd0,  e_data: 64'h0};
    tbl[1] = '{wb: 1'b1, rd: 5'd31, data: 64'hDEAD_BEEF_CAFE_F00D, e_rd: 5'd31, e_data: 64'hDEAD_BEEF_CAFE_F00D};
    tbl[2] = '{wb: 1'b0, rd: 5'd12, data: 64'h1234,                e_rd: 5'd0,  e_data: 64'h0};
    tbl[3] = '{wb: 1'b0, rd: 5'd0,  data: 64'h77,                  e_rd: 5'd0,  e_data: 64'h0};
    tbl[4] = '{wb: 1'b1, rd: 5'd1,  data: 64'hFFFF_FFFF_FFFF_FFFF, e_rd: 5'd1,  e_data: 64'hFFFF_FFFF_FFFF_FFFF};
    tbl[5] = '{wb: 1'b1, rd: 5'd17, data: 64'h0,                   e_rd: 5'd17, e_data: 64'h0};

    // Reset state
    do_reset();
    chk("rst_valid",   64'(trace_valid_o), 64'd0);
    chk("rst_pc",      trace_pc_o,         64'd0);
    chk("rst_inst",    64'(trace_inst_o),  64'd0);
    chk("rst_rd",      64'(trace_rd_o),    64'd0);
    chk("rst_data",    trace_data_o,       64'd0);
    chk("rst_seq",     64'(trace_seq_o),   64'd0);
    chk("rst_retire",  64'(retire_cnt_o),  64'd0);
    chk("rst_drop",    64'(drop_cnt_o),    64'd0);
    chk("rst_ovf",     64'(overflow_o),    64'd0);
    chk("rst_hang",    64'(hang_o),        64'd0);

    // Two-lane retire, second lane without writeback
    trace_ready_i = 1'b1;
    set_lane(0, 1'b1, 1'b1, 5'd5, 64'h1000, 32'h00A0_0293, 64'hAA);
    set_lane(1, 1'b1, 1'b0, 5'd7, 64'h1004, 32'h0000_0013, 64'h55);
    cycle();
    chk("t1_pc0",   trace_pc_o,        64'h1000);
    chk("t1_rd0",   64'(trace_rd_o),   64'd5);
    chk("t1_data0", trace_data_o,      64'hAA);
    chk("t1_seq0",  64'(trace_seq_o),  64'd0);
    clear_inputs();
    cycle();
    chk("t1_pc1",   trace_pc_o,        64'h1004);
    chk("t1_rd1",   64'(trace_rd_o),   64'd0);
    chk("t1_data1", trace_data_o,      64'd0);
    chk("t1_seq1",  64'(trace_seq_o),  64'd1);
    cycle();
    chk("t1_empty", 64'(trace_valid_o), 64'd0);

    // Normalisation table, single lane 0 retire per row
    for (int i = 0; i < 6; i++) begin
      clear_inputs();
      set_lane(0, 1'b1, tbl[i].wb, tbl[i].rd, 64'h3000 + 64'(4*i), 32'h33, tbl[i].data);
      cycle();
      chk($sformatf("norm%0d_valid", i), 64'(trace_valid_o), 64'd1);
      chk($sformatf("norm%0d_rd", i),    64'(trace_rd_o),    64'(tbl[i].e_rd));
      chk($sformatf("norm%0d_data", i),  trace_data_o,       tbl[i].e_data);
    end
    clear_inputs();
    cycle();

    // Overflow: 9 two-lane groups with the consumer stalled
    do_reset();
    trace_ready_i = 1'b0;
    fill_groups(9);
    chk("t3_drop",   64'(drop_cnt_o),   64'd2);
    chk("t3_ovf",    64'(overflow_o),   64'd1);
    chk("t3_retire", 64'(retire_cnt_o), 64'd18);
    chk("t3_head",   64'(trace_seq_o),  64'd0);

    // Full FIFO, pop and retire together: group still dropped
    trace_ready_i = 1'b1;
    fill_groups(1);
    chk("t4_drop",   64'(drop_cnt_o),   64'd4);
    chk("t4_retire", 64'(retire_cnt_o), 64'd20);
    clear_inputs();
    for (int i = 1; i < 16; i++) begin
      chk($sformatf("t3_seq%0d", i), 64'(trace_seq_o), 64'(i));
      cycle();
    end
    chk("t4_drained", 64'(trace_valid_o), 64'd0);

    // Watchdog
    do_reset();
    for (int i = 1; i < 8; i++) begin
      cycle();
      chk($sformatf("t5_idle%0d", i), 64'(hang_o), 64'd0);
    end
    cycle();
    chk("t5_hang", 64'(hang_o), 64'd1);
    trace_ready_i = 1'b1;
    set_lane(0, 1'b1, 1'b0, 5'd0, 64'h4000, 32'h13, 64'd0);
    cycle();
    chk("t5_clear", 64'(hang_o), 64'd0);
    clear_inputs();
    cycle();

    // Asynchronous reset with 5 entries queued and overflow set
    do_reset();
    fill_groups(9);
    clear_inputs();
    trace_ready_i = 1'b1;
    repeat (11) cycle();
    trace_ready_i = 1'b0;
    cycle();
    chk("t6_pre_ovf",  64'(overflow_o), 64'd1);
    chk("t6_pre_seq",  64'(trace_seq_o), 64'd11);
    #1;
    rst = 1'b1;
    #1;
    chk("t6_valid",  64'(trace_valid_o), 64'd0);
    chk("t6_retire", 64'(retire_cnt_o),  64'd0);
    chk("t6_ovf",    64'(overflow_o),    64'd0);
    chk("t6_drop",   64'(drop_cnt_o),    64'd0);
    do_reset();

    // Randomized traffic with stall phases and idle bursts
    for (int c = 0; c < 3000; c++) begin
      clear_inputs();
      if ((c % 250) < 230) begin
        for (int n = 0; n < NRET; n++) begin
          set_lane(n, 1'($urandom), 1'($urandom),
                   ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom),
                   {$urandom, $urandom}, $urandom, {$urandom, $urandom});
        end
      end
      trace_ready_i = ($urandom_range(0, 9) < (((c / 500) % 2 == 1) ? 3 : 8)) ? 1'b1 : 1'b0;
      cycle();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
